// File: rtl/ir_queue_pkg.sv
// Shared widths for the IFU->EXU IR queue.
// Holds E203 width defines and the packed payload width.
package ir_queue_pkg;

  localparam int E203_PC_SIZE     = 32;
  localparam int E203_RFIDX_WIDTH = 5;

  localparam int IRQ_IR_W   = 32;
  localparam int IRQ_FLAG_W = 5;

  // ir + pc + {pc_vld,misalgn,buserr,prdt_taken,muldiv_b2b} + rs1 + rs2
  function automatic int irq_payload_w(input int pc_w, input int rfidx_w);
    return IRQ_IR_W + pc_w + IRQ_FLAG_W + 2 * rfidx_w;
  endfunction

  localparam int IRQ_PAYLOAD_W =
    irq_payload_w(E203_PC_SIZE, E203_RFIDX_WIDTH);

endpackage

// File: rtl/ir_queue_ram.sv
// IR queue storage: flop array, one write port, async read.
// No reset on the array; validity is tracked by the pointers.
module ir_queue_ram
  import ir_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = IRQ_PAYLOAD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// IFU->EXU instruction queue with flush and no bypass.
// Pointers, occupancy and handshakes live here.
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = E203_PC_SIZE,
  parameter int RFIDX_W = E203_RFIDX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [31:0]                i_ir,
  input  logic [PC_W-1:0]            i_pc,
  input  logic                       i_pc_vld,
  input  logic                       i_misalgn,
  input  logic                       i_buserr,
  input  logic                       i_prdt_taken,
  input  logic                       i_muldiv_b2b,
  input  logic [RFIDX_W-1:0]         i_rs1idx,
  input  logic [RFIDX_W-1:0]         i_rs2idx,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [31:0]                o_ir,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_pc_vld,
  output logic                       o_misalgn,
  output logic                       o_buserr,
  output logic [RFIDX_W-1:0]         o_rs1idx,
  output logic [RFIDX_W-1:0]         o_rs2idx,
  output logic                       o_prdt_taken,
  output logic                       o_muldiv_b2b,
  input  logic                       flush_req,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       q_empty,
  output logic                       q_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = irq_payload_w(PC_W, RFIDX_W);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [PW-1:0] wdata;
  logic [PW-1:0] rdata;

  assign q_full  = (q_count == CW'(DEPTH));
  assign q_empty = (q_count == '0);
  assign i_ready = !q_full && !flush_req;
  assign o_valid = !q_empty && !flush_req;
  assign push    = i_valid && i_ready;
  assign pop     = o_valid && o_ready;

  assign wdata = {i_ir, i_pc, i_pc_vld, i_misalgn, i_buserr,
                  i_prdt_taken, i_muldiv_b2b, i_rs1idx, i_rs2idx};

  assign {o_ir, o_pc, o_pc_vld, o_misalgn, o_buserr,
          o_prdt_taken, o_muldiv_b2b, o_rs1idx, o_rs2idx} = rdata;

  // Pointer and occupancy update; flush beats push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush_req) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      q_count <= q_count + CW'(1);
      else if (pop && !push) q_count <= q_count - CW'(1);
    end
  end

  ir_queue_ram #(
    .DEPTH (DEPTH),
    .W     (PW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Directed + random bench for ir_queue against a queue model.
// Model keeps an ordered list of accepted payloads.
module tb_ir_queue;

  localparam int PW = 79;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_ir;
  logic [31:0] i_pc;
  logic        i_pc_vld;
  logic        i_misalgn;
  logic        i_buserr;
  logic        i_prdt_taken;
  logic        i_muldiv_b2b;
  logic [4:0]  i_rs1idx;
  logic [4:0]  i_rs2idx;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        o_pc_vld;
  logic        o_misalgn;
  logic        o_buserr;
  logic [4:0]  o_rs1idx;
  logic [4:0]  o_rs2idx;
  logic        o_prdt_taken;
  logic        o_muldiv_b2b;
  logic        flush_req;
  logic [2:0]  q_count;
  logic        q_empty;
  logic        q_full;

  int total;
  int bad;
  logic [PW-1:0] q [$];

  ir_queue dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_ir         (i_ir),
    .i_pc         (i_pc),
    .i_pc_vld     (i_pc_vld),
    .i_misalgn    (i_misalgn),
    .i_buserr     (i_buserr),
    .i_prdt_taken (i_prdt_taken),
    .i_muldiv_b2b (i_muldiv_b2b),
    .i_rs1idx     (i_rs1idx),
    .i_rs2idx     (i_rs2idx),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_ir         (o_ir),
    .o_pc         (o_pc),
    .o_pc_vld     (o_pc_vld),
    .o_misalgn    (o_misalgn),
    .o_buserr     (o_buserr),
    .o_rs1idx     (o_rs1idx),
    .o_rs2idx     (o_rs2idx),
    .o_prdt_taken (o_prdt_taken),
    .o_muldiv_b2b (o_muldiv_b2b),
    .flush_req    (flush_req),
    .q_count      (q_count),
    .q_empty      (q_empty),
    .q_full       (q_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack_in();
    return {i_ir, i_pc, i_pc_vld, i_misalgn, i_buserr,
            i_prdt_taken, i_muldiv_b2b, i_rs1idx, i_rs2idx};
  endfunction

  function automatic logic [PW-1:0] pack_out();
    return {o_ir, o_pc, o_pc_vld, o_misalgn, o_buserr,
            o_prdt_taken, o_muldiv_b2b, o_rs1idx, o_rs2idx};
  endfunction

  task automatic rand_payload();
    i_ir         = $urandom;
    i_pc         = $urandom;
    i_pc_vld     = 1'($urandom);
    i_misalgn    = 1'($urandom);
    i_buserr     = 1'($urandom);
    i_prdt_taken = 1'($urandom);
    i_muldiv_b2b = 1'($urandom);
    i_rs1idx     = 5'($urandom);
    i_rs2idx     = 5'($urandom);
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic cycle();
    bit ev;
    bit er;
    bit push;
    bit pop;
    logic [PW-1:0] pin;
    #1;
    ev = (q.size() != 0) && !flush_req;
    er = (q.size() < 4) && !flush_req;
    check("o_valid", 128'(o_valid), 128'(ev));
    check("i_ready", 128'(i_ready), 128'(er));
    check("q_count", 128'(q_count), 128'(q.size()));
    check("q_empty", 128'(q_empty), 128'(q.size() == 0));
    check("q_full",  128'(q_full),  128'(q.size() == 4));
    if (ev) check("payload", 128'(pack_out()), 128'(q[0]));
    push = i_valid && er;
    pop  = o_ready && ev;
    pin  = pack_in();
    @(posedge clk);
    #1;
    if (flush_req) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(pin);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    flush_req = 1'b0;
    rand_payload();
    #2;
    check("rst_o_valid", 128'(o_valid), 128'(0));
    check("rst_i_ready", 128'(i_ready), 128'(1));
    check("rst_q_empty", 128'(q_empty), 128'(1));
    check("rst_q_full",  128'(q_full),  128'(0));
    check("rst_q_count", 128'(q_count), 128'(0));
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with four sequential PCs while EXU stalls.
    for (int k = 0; k < 4; k++) begin
      rand_payload();
      i_valid = 1'b1;
      i_pc = 32'h8000_0000 + 32'(4 * k);
      cycle();
    end
    i_valid = 1'b0;
    #1;
    check("fill_q_full", 128'(q_full), 128'(1));
    check("fill_i_ready", 128'(i_ready), 128'(0));
    check("fill_o_pc", 128'(o_pc), 128'(32'h8000_0000));

    // Drain in order.
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_pc", 128'(o_pc), 128'(32'h8000_0000 + 32'(4 * k)));
      cycle();
    end
    #1;
    check("drain_empty", 128'(q_empty), 128'(1));
    check("drain_o_valid", 128'(o_valid), 128'(0));

    // Two entries, then steady push+pop with wraparound.
    o_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_payload();
      i_valid = 1'b1;
      cycle();
    end
    o_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_payload();
      cycle();
      check("stream_count", 128'(q_count), 128'(2));
    end

    // Bring occupancy to 3, then flush with a push offered.
    o_ready = 1'b0;
    rand_payload();
    cycle();
    check("pre_flush_count", 128'(q_count), 128'(3));
    flush_req = 1'b1;
    rand_payload();
    #1;
    check("flush_o_valid", 128'(o_valid), 128'(0));
    check("flush_i_ready", 128'(i_ready), 128'(0));
    cycle();
    flush_req = 1'b0;
    i_valid = 1'b0;
    #1;
    check("post_flush_count", 128'(q_count), 128'(0));
    check("post_flush_valid", 128'(o_valid), 128'(0));

    // Two entries then an async reset pulse mid-cycle.
    for (int k = 0; k < 2; k++) begin
      rand_payload();
      i_valid = 1'b1;
      cycle();
    end
    i_valid = 1'b0;
    check("pre_rst_count", 128'(q_count), 128'(2));
    #2;
    rst = 1'b1;
    #1;
    check("arst_o_valid", 128'(o_valid), 128'(0));
    check("arst_q_count", 128'(q_count), 128'(0));
    q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rand_payload();
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    #1;
    check("first_after_rst", 128'(o_valid), 128'(1));
    cycle();

    // Exception flags and max register index pass through.
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    rand_payload();
    i_valid = 1'b1;
    i_buserr = 1'b1;
    i_misalgn = 1'b1;
    i_prdt_taken = 1'b1;
    i_rs1idx = 5'd31;
    cycle();
    i_valid = 1'b0;
    #1;
    check("flag_buserr", 128'(o_buserr), 128'(1));
    check("flag_misalgn", 128'(o_misalgn), 128'(1));
    check("flag_prdt", 128'(o_prdt_taken), 128'(1));
    check("flag_rs1", 128'(o_rs1idx), 128'(31));

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      i_valid = 1'($urandom);
      o_ready = ($urandom_range(3) != 0);
      flush_req = ($urandom_range(19) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
